// File: rtl/grant_burst_unit.sv
// grant_burst_unit
// Takes the grant outputs of the two-requester arbiter. While a requester
// holds its grant, a fixed-length burst of its words is moved onto one shared
// output channel. The channel has a one-entry registered output stage with a
// valid/ready handshake. The block reports burst completion, early abort and
// overlapping grants back toward the requesters.

module grant_burst_unit #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_res,
  input  logic              b_res,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              a_done,
  output logic              b_done,
  output logic              abort,
  output logic              grant_err
);

  // Each counter is wide enough to hold its terminal value. Neither counter
  // ever has to wrap.
  localparam int BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_LEN);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_A = 2'd1,
    BURST_B = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_inc;
  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_inc;

  logic can_load;
  logic in_burst;
  logic grant_held;
  logic grant_lost;
  logic xfer_a;
  logic xfer_b;
  logic xfer;
  logic last_beat;
  logic timeout_hit;

  // A new word can enter the output register if the register is empty or
  // if its current word is leaving on this same cycle.
  assign can_load = !out_valid || out_ready;

  assign in_burst   = (state_q == BURST_A) || (state_q == BURST_B);
  assign grant_held = ((state_q == BURST_A) && a_res) ||
                      ((state_q == BURST_B) && b_res);
  assign grant_lost = in_burst && !grant_held;

  // The readies are gated by the grant, so a cycle that loses the grant
  // can never also transfer a beat.
  assign xfer_a = a_valid && a_ready;
  assign xfer_b = b_valid && b_ready;
  assign xfer   = xfer_a || xfer_b;

  assign beat_inc  = beat_cnt + BEAT_W'(1);
  assign stall_inc = stall_cnt + STALL_W'(1);

  assign last_beat   = xfer && (beat_inc == BEAT_LAST);
  assign timeout_hit = grant_held && !xfer && (stall_inc == STALL_MAX);

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples its pre-edge value, regardless of the order of the blocks.
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a grant is evaluated only in IDLE. Inside a burst the
  // exit priority is grant loss, then completion, then timeout.
  always_comb begin
    // NOTE: the default assignment at the top makes every path drive
    // state_d, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_res && !b_res) begin
          state_d = BURST_A;
        end else if (b_res && !a_res) begin
          state_d = BURST_B;
        end
      end
      BURST_A, BURST_B: begin
        if (grant_lost) begin
          state_d = IDLE;
        end else if (last_beat) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the requester that owns the burst and still holds
  // its grant sees ready, and only when the output register can take a word.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      BURST_A: a_ready = a_res && can_load;
      BURST_B: b_ready = b_res && can_load;
      default: begin
        a_ready = 1'b0;
        b_ready = 1'b0;
      end
    endcase
  end

  // Beat and stall counters: held at zero in IDLE, so every burst starts
  // from a clean count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else if (!in_burst) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else if (xfer) begin
      if (beat_cnt != BEAT_LAST) begin
        beat_cnt <= beat_inc;
      end
      stall_cnt <= '0;
    end else if (grant_held && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_inc;
    end
  end

  // One-entry output stage: a load replaces the word, a drain alone empties
  // it. Aborts and completions leave a held word in place to drain normally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_b ? b_data : a_data;
      out_src   <= xfer_b;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status pulses for the requesters, plus the sticky overlapping-grant flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      abort     <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      a_done <= xfer_a && (beat_inc == BEAT_LAST);
      b_done <= xfer_b && (beat_inc == BEAT_LAST);
      abort  <= grant_lost || timeout_hit;
      if ((state_q == IDLE) && a_res && b_res) begin
        grant_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grant_burst_unit.sv
// Bench for grant_burst_unit. The stimulus process drives directed and
// random inputs and steps a burst-level reference model. The model pushes
// expected status and expected output words into queues. A monitor process
// pops those queues and compares them with what the DUT presents.

module tb_grant_burst_unit;

  localparam int DATA_W    = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 8;

  logic              clock;
  logic              reset;
  logic              a_res;
  logic              b_res;
  logic              a_valid;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;
  logic              a_done;
  logic              b_done;
  logic              abort;
  logic              grant_err;

  grant_burst_unit #(
    .DATA_W   (DATA_W),
    .BURST_LEN(BURST_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .a_res    (a_res),
    .b_res    (b_res),
    .a_valid  (a_valid),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .a_done   (a_done),
    .b_done   (b_done),
    .abort    (abort),
    .grant_err(grant_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues: {a_done,b_done,abort,out_valid,grant_err} per cycle,
  // and {src,data} for each word accepted into the output stage.
  logic [4:0]        status_q[$];
  logic [DATA_W:0]   exp_q[$];

  // Reference model: burst owner (0 none, 1 A, 2 B), beats still owed,
  // consecutive stalls, and the expected visible outputs.
  int  m_owner      = 0;
  int  m_beats_left = 0;
  int  m_stalls     = 0;
  bit  m_full       = 1'b0;
  bit  m_a_done     = 1'b0;
  bit  m_b_done     = 1'b0;
  bit  m_abort      = 1'b0;
  bit  m_gerr       = 1'b0;

  logic [DATA_W-1:0] a_word = 8'h10;
  logic [DATA_W-1:0] b_word = 8'h40;
  bit                rand_data = 1'b0;

  // The inputs for this cycle are already driven. This task checks the
  // readies, records the expected outputs, advances the model across the
  // coming posedge and then waits for the next negedge.
  task automatic tick();
    bit can_load, exp_ar, exp_br, acc_a, acc_b, have;
    #1;
    can_load = !m_full || out_ready;
    exp_ar   = (m_owner == 1) && a_res && can_load;
    exp_br   = (m_owner == 2) && b_res && can_load;
    check("a_ready", 32'(a_ready), 32'(exp_ar));
    check("b_ready", 32'(b_ready), 32'(exp_br));
    status_q.push_back({m_a_done, m_b_done, m_abort, m_full, m_gerr});
    acc_a    = exp_ar && a_valid;
    acc_b    = exp_br && b_valid;
    m_a_done = 1'b0;
    m_b_done = 1'b0;
    m_abort  = 1'b0;
    if (!reset) begin
      if (m_full && exp_q.size() > 0) void'(exp_q.pop_back());
      m_full = 1'b0; m_gerr = 1'b0; m_owner = 0; m_beats_left = 0; m_stalls = 0;
    end else begin
      if (m_owner == 0) begin
        if (a_res && b_res) m_gerr = 1'b1;
        else if (a_res) begin m_owner = 1; m_beats_left = BURST_LEN; m_stalls = 0; end
        else if (b_res) begin m_owner = 2; m_beats_left = BURST_LEN; m_stalls = 0; end
      end else begin
        have = (m_owner == 1) ? a_res : b_res;
        if (!have) begin
          m_abort = 1'b1;
          m_owner = 0;
        end else if (acc_a || acc_b) begin
          exp_q.push_back(acc_a ? {1'b0, a_data} : {1'b1, b_data});
          m_beats_left--;
          m_stalls = 0;
          if (m_beats_left == 0) begin
            if (m_owner == 1) m_a_done = 1'b1;
            else              m_b_done = 1'b1;
            m_owner = 0;
          end
        end else begin
          m_stalls++;
          if (m_stalls == TIMEOUT) begin
            m_abort = 1'b1;
            m_owner = 0;
          end
        end
      end
      m_full = acc_a || acc_b || (m_full && !out_ready);
      if (acc_a) a_word = rand_data ? DATA_W'($urandom) : a_word + 1'b1;
      if (acc_b) b_word = rand_data ? DATA_W'($urandom) : b_word + 1'b1;
    end
    @(negedge clock);
  endtask

  // Drive one cycle of inputs. Sources present their current word. While
  // reset is low the valids and out_ready are held low.
  task automatic drive(input bit rst_v, input bit ar, input bit br,
                       input bit av, input bit bv, input bit ordy);
    reset     = rst_v;
    a_res     = ar;
    b_res     = br;
    a_valid   = rst_v ? av : 1'b0;
    b_valid   = rst_v ? bv : 1'b0;
    out_ready = rst_v ? ordy : 1'b0;
    a_data    = a_word;
    b_data    = b_word;
    tick();
  endtask

  // Monitor: takes one expected status per cycle and one expected word for
  // each handshake that completes at the coming posedge.
  always @(negedge clock) begin
    logic [4:0]      s;
    logic [DATA_W:0] w;
    #3;
    if (status_q.size() > 0) begin
      s = status_q.pop_front();
      check("status", 32'({a_done, b_done, abort, out_valid, grant_err}), 32'(s));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'({out_src, out_data}), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        check("out_word", 32'({out_src, out_data}), 32'(w));
      end
    end
  end

  initial begin
    bit ar, br;
    int vprob;
    reset = 1'b0; a_res = 1'b0; b_res = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; out_ready = 1'b0;
    @(negedge clock);

    // Reset for two cycles, then idle.
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_src", 32'(out_src), 32'h0);

    // A burst of 10..13 with a free-running output.
    a_word = 8'h10;
    repeat (5) drive(1, 1, 0, 1, 0, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1);

    // B burst with out_ready low for three cycles after the first beat.
    repeat (2) drive(1, 0, 1, 0, 1, 1);
    repeat (3) drive(1, 0, 1, 0, 1, 0);
    repeat (5) drive(1, 0, 1, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1);

    // Timeout: grant held with no data for TIMEOUT stall cycles.
    repeat (TIMEOUT + 1) drive(1, 1, 0, 0, 0, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1);

    // Grant moves from A to B after two A beats.
    repeat (3) drive(1, 1, 0, 1, 0, 1);
    repeat (7) drive(1, 0, 1, 0, 1, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1);

    // Overlapping grants set the sticky error; reset clears it.
    repeat (3) drive(1, 1, 1, 1, 1, 1);
    repeat (3) drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);

    // Reset lands in the middle of a burst while a word is held.
    repeat (3) drive(1, 1, 0, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 0, 0, 0, 1);

    // Random traffic with persistent grants and phases of sparse data.
    rand_data = 1'b1;
    ar = 1'b0;
    br = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) ar = !ar;
      if ($urandom_range(0, 9) == 0) br = !br;
      vprob = ((i / 64) % 2 == 1) ? 1 : 3;
      drive($urandom_range(0, 299) != 0, ar, br,
            $urandom_range(0, 3) < vprob, $urandom_range(0, 3) < vprob,
            $urandom_range(0, 9) < 7);
    end

    // Drain anything left and confirm every expected word appeared.
    repeat (6) drive(1, 0, 0, 0, 0, 1);
    #5;
    check("words_left", 32'(exp_q.size()), 32'h0);
    check("status_left", 32'(status_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_burst_unit.md
Name: grant_burst_unit

Overview:
- Sits directly downstream of the two-requester arbiter and consumes its grant outputs (a_res, b_res).
- While a requester holds the grant, moves a fixed-length burst of data words from that requester onto a single shared output channel through a one-entry registered output stage with valid/ready handshake.
- Reports burst completion, abort and protocol errors back toward the requesters.

Parameters:
- DATA_W, 8, width of the data words.
- BURST_LEN, 4, beats per burst (>=1).
- TIMEOUT, 8, consecutive stall cycles inside a burst before it aborts (>=1).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (reset==0 at a posedge resets the block).
- a_res  in  1  grant to requester A, from the arbiter.
- b_res  in  1  grant to requester B, from the arbiter.
- a_valid  in  1  A has a word on a_data.
- a_data  in  DATA_W  A source word.
- a_ready  out  1  A word accepted this cycle when a_valid&&a_ready.
- b_valid  in  1  B has a word on b_data.
- b_data  in  DATA_W  B source word.
- b_ready  out  1  B word accepted this cycle when b_valid&&b_ready.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  output word.
- out_src  out  1  source of out_data (0=A, 1=B).
- out_ready  in  1  downstream consumes the word when out_valid&&out_ready.
- a_done  out  1  one-cycle pulse: A burst completed.
- b_done  out  1  one-cycle pulse: B burst completed.
- abort  out  1  one-cycle pulse: active burst terminated early.
- grant_err  out  1  sticky: both grants seen high together.

Behaviour:
- Reset (reset==0): state=IDLE; beat and stall counters=0; out_valid=0, out_data=0, out_src=0; a_done=b_done=abort=0; grant_err=0. Reset overrides any in-flight burst and any held output word; that word is dropped.
- States: IDLE, BURST_A, BURST_B.
- IDLE:
  - a_res&&!b_res -> BURST_A.
  - b_res&&!a_res -> BURST_B.
  - Both high -> stay IDLE, set grant_err.
  - Neither -> stay IDLE.
  - Beat and stall counters cleared on entry to either BURST state.
- can_load = !out_valid || out_ready (output register empty or draining this cycle).
- BURST_A: a_ready=can_load; b_ready=0. BURST_B is symmetric. IDLE: both readies 0.
- Beat transfer (a_valid&&a_ready):
  - out_data<=a_data, out_src<=0, out_valid<=1 next cycle.
  - Beat counter increments; stall counter clears.
  - The beat that makes the count equal BURST_LEN also pulses a_done the next cycle and returns to IDLE. Latency is 1 cycle from accept to out_valid.
- Output drain: out_valid&&out_ready with no new load -> out_valid<=0. Simultaneous drain and load -> out_valid stays 1 with the new word (full throughput, 1 beat/cycle).
- Stall: in a BURST state a cycle without a transfer increments the stall counter. When it reaches TIMEOUT -> abort pulse, go IDLE, no done pulse.
- Grant loss: in BURST_A with a_res==0 (regardless of b_res) -> abort pulse, go IDLE that cycle. No transfer occurs in that cycle: a_ready is gated by a_res. BURST_B is symmetric.
- Priority within a cycle: reset > grant loss > completion > timeout.
- Abort and completion never drop the word already in the output register; it drains normally.
- Any new burst needs a fresh grant evaluation in IDLE, so back-to-back bursts have at least 1 IDLE cycle between them.
- BURST_LEN=1: the first accepted beat completes the burst.
- grant_err is cleared only by reset.
- Counter widths: $clog2(BURST_LEN+1) and $clog2(TIMEOUT+1). Counters never wrap.

Test Plan:
- Reset low 2 cycles, then high with idle inputs -> all outputs 0; state IDLE.
- a_res=1, a_valid=1, a_data=8'h10..8'h13 on consecutive cycles, out_ready=1 -> out_data 10,11,12,13 on 4 consecutive cycles with out_src=0. a_done pulses 1 cycle after the 4th accept. Back in IDLE.
- B burst with out_ready=0 for 3 cycles after the first beat -> b_ready=0 while the register is full, out_data holds the first word, no loss or duplication. Completes with b_done. Stall counter resets on each beat, so no abort.
- a_res=1, a_valid=0 for 8 cycles (TIMEOUT=8) -> abort pulse on the 8th stall, a_done never asserted, return to IDLE.
- Mid-burst after 2 beats, a_res->0 and b_res->1 -> abort pulse, last A word still drains. Next cycle enters BURST_B, and B beats appear with out_src=1.
- a_res=b_res=1 in IDLE -> grant_err=1 and stays 1; no ready asserted. Reset low clears it. Reset asserted mid-burst -> out_valid=0 next cycle.
